// File: rtl/local_mem_bank_bridge.sv
// local_mem_bank_bridge: per-bank command FIFO, read-credit tracker, read-data register and status flags.
module local_mem_bank_bridge #(
  parameter int ADDR_WIDTH       = 27,
  parameter int DATA_WIDTH       = 512,
  parameter int BYTEEN_WIDTH     = 64,
  parameter int BURSTCOUNT_WIDTH = 7,
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_RD_BEATS     = 128,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                clk,
  input  logic                                SoftReset,
  input  logic                                s_read,
  input  logic                                s_write,
  input  logic [ADDR_WIDTH-1:0]               s_address,
  input  logic [DATA_WIDTH-1:0]               s_writedata,
  input  logic [BYTEEN_WIDTH-1:0]             s_byteenable,
  input  logic [BURSTCOUNT_WIDTH-1:0]         s_burstcount,
  output logic                                s_waitrequest,
  output logic [DATA_WIDTH-1:0]               s_readdata,
  output logic                                s_readdatavalid,
  output logic                                m_read,
  output logic                                m_write,
  output logic [ADDR_WIDTH-1:0]               m_address,
  output logic [DATA_WIDTH-1:0]               m_writedata,
  output logic [BYTEEN_WIDTH-1:0]             m_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0]         m_burstcount,
  input  logic                                m_waitrequest,
  input  logic [DATA_WIDTH-1:0]               m_readdata,
  input  logic                                m_readdatavalid,
  output logic [$clog2(MAX_RD_BEATS+1)-1:0]   rd_outstanding,
  output logic [31:0]                         wr_count,
  output logic [31:0]                         rd_count,
  output logic [3:0]                          err_flags,
  output logic                                rd_timeout
);
  localparam int MAXB = 1 << (BURSTCOUNT_WIDTH - 1);
  localparam int OW   = $clog2(MAX_RD_BEATS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  typedef struct packed {
    logic                        is_wr;
    logic [ADDR_WIDTH-1:0]       address;
    logic [DATA_WIDTH-1:0]       writedata;
    logic [BYTEEN_WIDTH-1:0]     byteenable;
    logic [BURSTCOUNT_WIDTH-1:0] burstcount;
  } entry_t;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer, timer_nxt;
  logic          accept, acc_wr, acc_rd, push, pop, beat_ok, has_head;
  always_comb begin
    s_waitrequest = (count == (AW+1)'(FIFO_DEPTH)) || (rd_outstanding > OW'(MAX_RD_BEATS - MAXB));
    accept        = (s_read || s_write) && !s_waitrequest;
    acc_wr        = accept && s_write;
    acc_rd        = accept && s_read && !s_write;
    push          = accept && (s_burstcount != '0);
    has_head      = count != '0;
    pop           = has_head && !m_waitrequest;
    head          = mem[rd_ptr];
    m_read        = has_head && !head.is_wr;
    m_write       = has_head && head.is_wr;
    m_address     = head.address;
    m_writedata   = head.writedata;
    m_byteenable  = head.byteenable;
    m_burstcount  = head.burstcount;
    beat_ok       = m_readdatavalid && (rd_outstanding != '0);
    timer_nxt     = (rd_outstanding == '0 || m_readdatavalid) ? '0 :
                    (timer == TW'(TIMEOUT_CYCLES)) ? timer : timer + TW'(1);
  end
  // Payload storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk)
    if (push)
      mem[wr_ptr] <= {s_write, s_address, s_writedata, s_byteenable,
                      s_write ? BURSTCOUNT_WIDTH'(1) : s_burstcount};
  always_ff @(posedge clk) s_readdata <= m_readdata;
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rd_outstanding  <= '0;
      wr_count        <= '0;
      rd_count        <= '0;
      err_flags       <= '0;
      rd_timeout      <= 1'b0;
      timer           <= '0;
      s_readdatavalid <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr + AW'(push);
      rd_ptr          <= rd_ptr + AW'(pop);
      count           <= count + (AW+1)'(push) - (AW+1)'(pop);
      rd_outstanding  <= rd_outstanding + (acc_rd ? OW'(s_burstcount) : OW'(0)) - OW'(beat_ok);
      wr_count        <= wr_count + 32'(acc_wr);
      rd_count        <= rd_count + 32'(acc_rd);
      err_flags       <= err_flags | {m_readdatavalid && (rd_outstanding == '0),
                                      accept && (s_burstcount == '0),
                                      acc_wr && (s_burstcount > BURSTCOUNT_WIDTH'(1)),
                                      accept && s_read && s_write};
      timer           <= timer_nxt;
      rd_timeout      <= rd_timeout || (timer_nxt == TW'(TIMEOUT_CYCLES));
      s_readdatavalid <= beat_ok;
    end
  end
endmodule

// File: tb/tb_local_mem_bank_bridge.sv
// tb_local_mem_bank_bridge: directed plus random stimulus checked against a queue-level model every cycle.
module tb_local_mem_bank_bridge;
  localparam int AW = 27, DW = 512, BW = 64, CW = 7, D = 4, MAXR = 128, TO = 1024, MAXB = 64;
  logic clk = 0, SoftReset;
  logic s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [AW-1:0] s_address, m_address;
  logic [DW-1:0] s_writedata, s_readdata, m_writedata, m_readdata;
  logic [BW-1:0] s_byteenable, m_byteenable;
  logic [CW-1:0] s_burstcount, m_burstcount;
  logic m_read, m_write, m_waitrequest, m_readdatavalid, rd_timeout;
  logic [7:0] rd_outstanding;
  logic [31:0] wr_count, rd_count;
  logic [3:0] err_flags;

  local_mem_bank_bridge dut (
    .clk(clk), .SoftReset(SoftReset), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .rd_outstanding(rd_outstanding), .wr_count(wr_count),
    .rd_count(rd_count), .err_flags(err_flags), .rd_timeout(rd_timeout));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, pulses = 0;
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    bit w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    logic [CW-1:0] bc;
  } ent_t;
  ent_t q[$];
  int mo, tmr;
  logic [31:0] wc, rc;
  logic [3:0] ef;
  bit to, erdv, live = 0;
  logic [DW-1:0] erd;

  // Reference model: bank requests as a queue, credits/flags as plain counters.
  always @(posedge clk) begin
    bit acc, accw, accr, beat;
    if (SoftReset) begin
      q.delete(); mo = 0; tmr = 0; wc = 0; rc = 0; ef = 0; to = 0; erdv = 0; live = 1;
    end else if (live) begin
      acc  = (s_read || s_write) && !(q.size() == D || mo > MAXR - MAXB);
      accw = acc && s_write;
      accr = acc && s_read && !s_write;
      if (q.size() > 0 && !m_waitrequest) void'(q.pop_front());
      if (acc && s_burstcount != 0)
        q.push_back('{s_write, s_address, s_writedata, s_byteenable, s_write ? 7'd1 : s_burstcount});
      beat = m_readdatavalid && mo > 0;
      if (acc && s_read && s_write) ef[0] = 1;
      if (accw && s_burstcount > 1) ef[1] = 1;
      if (acc && s_burstcount == 0) ef[2] = 1;
      if (m_readdatavalid && mo == 0) ef[3] = 1;
      if (mo == 0 || m_readdatavalid) tmr = 0;
      else if (tmr < TO) tmr++;
      if (tmr == TO) to = 1;
      wc = wc + 32'(accw);
      rc = rc + 32'(accr);
      mo = mo + (accr ? int'(s_burstcount) : 0) - int'(beat);
      erdv = beat;
      erd = m_readdata;
    end
  end

  always @(negedge clk) if (live) begin
    chk("s_waitrequest", s_waitrequest, q.size() == D || mo > MAXR - MAXB);
    chk("m_read", m_read, q.size() > 0 && !q[0].w);
    chk("m_write", m_write, q.size() > 0 && q[0].w);
    if (q.size() > 0) begin
      chk("m_address", m_address, q[0].a);
      chk("m_burstcount", m_burstcount, q[0].bc);
      if (q[0].w) begin
        chk("m_writedata", m_writedata, q[0].d);
        chk("m_byteenable", m_byteenable, q[0].be);
      end
    end
    chk("rd_outstanding", rd_outstanding, mo);
    chk("wr_count", wr_count, wc);
    chk("rd_count", rd_count, rc);
    chk("err_flags", err_flags, ef);
    chk("rd_timeout", rd_timeout, to);
    chk("s_readdatavalid", s_readdatavalid, erdv);
    if (erdv) chk("s_readdata", s_readdata, erd);
    if (s_readdatavalid) pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic req(input bit r, input bit w, input logic [AW-1:0] a, input logic [CW-1:0] bc);
    s_read = r; s_write = w; s_address = a; s_burstcount = bc;
    s_writedata = {16{$urandom}}; s_byteenable = {$urandom, $urandom};
    tick(1);
    s_read = 0; s_write = 0;
  endtask
  task automatic beats(input int n);
    m_readdatavalid = 1;
    repeat (n) begin m_readdata = {16{$urandom}}; tick(1); end
    m_readdatavalid = 0;
  endtask

  initial begin
    int base;
    SoftReset = 1; s_read = 0; s_write = 0; s_address = 0; s_writedata = 0; s_byteenable = 0;
    s_burstcount = 1; m_waitrequest = 0; m_readdata = 0; m_readdatavalid = 0;
    tick(3);
    SoftReset = 0;
    @(negedge clk);
    chk("reset rd_outstanding", rd_outstanding, 0);
    chk("reset s_waitrequest", s_waitrequest, 0);
    chk("reset m_write", m_write, 0);
    chk("reset err_flags", err_flags, 0);
    // single write
    s_write = 1; s_address = 'h10; s_writedata = {64{8'hA5}}; s_byteenable = '1; s_burstcount = 1;
    tick(1);
    s_write = 0;
    @(negedge clk);
    chk("single m_write", m_write, 1);
    chk("single m_address", m_address, 'h10);
    chk("single m_writedata", m_writedata, {64{8'hA5}});
    @(negedge clk);
    chk("single m_write drop", m_write, 0);
    chk("single wr_count", wr_count, 1);
    // fill FIFO under back-pressure
    m_waitrequest = 1;
    for (int i = 0; i < 6; i++) req(0, 1, AW'('h100 + i), 1);
    @(negedge clk);
    chk("full s_waitrequest", s_waitrequest, 1);
    chk("full wr_count", wr_count, 5);
    chk("full head", m_address, 'h100);
    m_waitrequest = 0;
    @(negedge clk);
    chk("drain second", m_address, 'h101);
    tick(5);
    // read credits
    @(negedge clk);
    req(1, 0, 'h2000, 64);
    @(negedge clk);
    chk("rd64 outstanding", rd_outstanding, 64);
    chk("rd64 s_waitrequest", s_waitrequest, 0);
    req(1, 0, 'h3000, 64);
    @(negedge clk);
    chk("rd128 outstanding", rd_outstanding, 128);
    chk("rd128 s_waitrequest", s_waitrequest, 1);
    base = pulses;
    beats(64);
    tick(2);
    @(negedge clk);
    chk("beats64 pulses", pulses - base, 64);
    chk("beats64 outstanding", rd_outstanding, 64);
    chk("beats64 s_waitrequest", s_waitrequest, 0);
    beats(54);
    tick(1);
    m_readdatavalid = 1; m_readdata = {16{$urandom}};
    req(1, 0, 'h4000, 4);
    m_readdatavalid = 0;
    @(negedge clk);
    chk("net credit", rd_outstanding, 13);
    beats(13);
    tick(2);
    // watchdog
    req(1, 0, 'h5000, 1);
    tick(1000);
    @(negedge clk);
    chk("timeout early", rd_timeout, 0);
    tick(40);
    @(negedge clk);
    chk("timeout set", rd_timeout, 1);
    beats(1);
    @(negedge clk);
    chk("late beat valid", s_readdatavalid, 1);
    chk("late beat outstanding", rd_outstanding, 0);
    tick(5);
    @(negedge clk);
    chk("timeout sticky", rd_timeout, 1);
    // protocol errors
    req(1, 1, 'h6000, 1);
    @(negedge clk);
    chk("rw err0", err_flags[0], 1);
    chk("rw only write", {m_read, m_write}, 2'b01);
    req(0, 1, 'h6100, 4);
    @(negedge clk);
    chk("wburst m_burstcount", m_burstcount, 1);
    chk("wburst err1", err_flags[1], 1);
    req(1, 0, 'h6200, 0);
    @(negedge clk);
    chk("burst0 err2", err_flags[2], 1);
    req(1, 0, 'h7000, 8);
    beats(2);
    SoftReset = 1;
    tick(1);
    SoftReset = 0;
    base = pulses;
    beats(3);
    tick(1);
    @(negedge clk);
    chk("stray err_flags", err_flags, 4'b1000);
    chk("stray pulses", pulses - base, 0);
    chk("stray outstanding", rd_outstanding, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      s_read = ($urandom % 3) == 0;
      s_write = ($urandom % 4) == 0;
      s_address = AW'($urandom);
      s_writedata = {16{$urandom}};
      s_byteenable = {$urandom, $urandom};
      s_burstcount = ($urandom % 16 == 0) ? 7'd0 :
                     (($urandom % 4 == 0) ? CW'(1 + $urandom % 64) : CW'(1 + $urandom % 4));
      m_waitrequest = ($urandom % 3) == 0;
      m_readdatavalid = ($urandom % 2) == 0;
      m_readdata = {16{$urandom}};
      SoftReset = ($urandom % 700) == 0;
      tick(1);
    end
    s_read = 0; s_write = 0; m_readdatavalid = 0; m_waitrequest = 0; SoftReset = 0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
